// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues req/ack word fetches and
// buffers returned {pc, instr} pairs in a DEPTH-entry circular prefetch queue.
module fetch_queue #(
   parameter int          ADDR_WIDTH  = 16,
   parameter int          INSTR_WIDTH = 16,
   parameter int          DEPTH       = 4,
   parameter int unsigned RESET_PC    = 0,
   parameter int unsigned PC_STEP     = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   output logic                           imem_req,
   output logic [ADDR_WIDTH-1:0]          imem_addr,
   input  logic                           imem_ack,
   input  logic [INSTR_WIDTH-1:0]         imem_data,
   output logic [ADDR_WIDTH-1:0]          fetch_pc_next,
   input  logic                           redirect,
   input  logic [ADDR_WIDTH-1:0]          redirect_pc,
   output logic                           instr_valid,
   output logic [INSTR_WIDTH-1:0]         instr,
   output logic [ADDR_WIDTH-1:0]          instr_pc,
   input  logic                           instr_ready,
   output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PC_RST   = ADDR_WIDTH'(RESET_PC);
   localparam logic [ADDR_WIDTH-1:0] PC_INC   = ADDR_WIDTH'(PC_STEP);

   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [ADDR_WIDTH-1:0]  slot_pc_q    [DEPTH];
   logic [INSTR_WIDTH-1:0] slot_instr_q [DEPTH];

   logic push, pop;

   // Reset is muxed in so the reset cycle itself shows RESET_PC and an empty queue.
   assign imem_addr     = reset ? PC_RST : pc_q;
   assign fetch_pc_next = imem_addr + PC_INC;
   assign imem_req      = !reset && !redirect && (count_q < FULL_CNT);
   assign instr_valid   = !reset && (count_q != '0);
   assign instr         = instr_valid ? slot_instr_q[rd_ptr_q] : '0;
   assign instr_pc      = instr_valid ? slot_pc_q[rd_ptr_q]    : '0;
   assign occupancy     = reset ? '0 : count_q;

   assign push = imem_req && imem_ack;
   assign pop  = instr_valid && instr_ready;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect) begin
         pc_d     = redirect_pc;
         wr_ptr_d = rd_ptr_q;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_d     = fetch_pc_next;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         pc_q     <= PC_RST;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: queue storage is not reset; count gates every read, so stale slots are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         slot_pc_q[wr_ptr_q]    <= pc_q;
         slot_instr_q[wr_ptr_q] <= imem_data;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_fetch_queue;

   localparam int AW = 16;
   localparam int IW = 16;
   localparam int D  = 4;
   localparam int CW = $clog2(D+1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack = 1'b0;
   logic [IW-1:0] imem_data = '0;
   logic [AW-1:0] fetch_pc_next;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          instr_valid;
   logic [IW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          instr_ready = 1'b0;
   logic [CW-1:0] occupancy;

   fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(D), .RESET_PC(0), .PC_STEP(2)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .fetch_pc_next(fetch_pc_next), .redirect(redirect), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: fetch PC plus an ordered list of {pc, instr} entries.
   typedef struct packed { logic [AW-1:0] pc; logic [IW-1:0] ins; } entry_t;
   entry_t        mq[$];
   logic [AW-1:0] mpc = '0;

   always @(negedge clk) begin
      logic          e_req, e_valid;
      logic [AW-1:0] e_addr;
      e_req   = !reset && !redirect && (mq.size() < D);
      e_valid = !reset && (mq.size() != 0);
      e_addr  = reset ? AW'(0) : mpc;
      check("imem_req",      imem_req,      e_req);
      check("imem_addr",     imem_addr,     e_addr);
      check("fetch_pc_next", fetch_pc_next, AW'(e_addr + 2));
      check("instr_valid",   instr_valid,   e_valid);
      check("instr",         instr,         e_valid ? mq[0].ins : '0);
      check("instr_pc",      instr_pc,      e_valid ? mq[0].pc  : '0);
      check("occupancy",     occupancy,     reset ? 0 : mq.size());
      // Advance the model to the state after the coming rising edge.
      if (reset) begin
         mq.delete();
         mpc = '0;
      end else if (redirect) begin
         mq.delete();
         mpc = redirect_pc;
      end else begin
         if (e_valid && instr_ready) void'(mq.pop_front());
         if (e_req && imem_ack) begin
            mq.push_back('{pc: mpc, ins: imem_data});
            mpc = mpc + AW'(2);
         end
      end
   end

   // Apply one cycle of inputs shortly after the rising edge; return at the falling edge.
   task automatic cyc(input logic rst, input logic ack, input logic rdy,
                      input logic rdr = 1'b0, input logic [AW-1:0] rpc = '0);
      @(posedge clk);
      #1;
      reset       = rst;
      imem_ack    = ack;
      instr_ready = rdy;
      redirect    = rdr;
      redirect_pc = rpc;
      imem_data   = IW'($urandom);
      @(negedge clk);
   endtask

   initial begin
      // Reset cycle outputs.
      cyc(1, 1, 1);
      check("rst_req", imem_req, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_occ", occupancy, 0);
      check("rst_addr", imem_addr, 16'h0000);
      check("rst_next", fetch_pc_next, 16'h0002);

      // Streaming: ack every cycle, decode always ready.
      cyc(0, 1, 1);
      check("s_addr0", imem_addr, 16'h0000);
      check("s_req0", imem_req, 1);
      check("s_valid0", instr_valid, 0);
      cyc(0, 1, 1);
      check("s_addr1", imem_addr, 16'h0002);
      check("s_ipc1", instr_pc, 16'h0000);
      check("s_occ1", occupancy, 1);
      cyc(0, 1, 1);
      check("s_addr2", imem_addr, 16'h0004);
      check("s_ipc2", instr_pc, 16'h0002);
      cyc(0, 1, 1);
      check("s_addr3", imem_addr, 16'h0006);
      check("s_occ3", occupancy, 1);

      // Back-pressure fills the queue.
      cyc(1, 0, 0);
      repeat (4) cyc(0, 1, 0);
      cyc(0, 1, 0);
      check("full_occ", occupancy, 4);
      check("full_req", imem_req, 0);
      check("full_addr", imem_addr, 16'h0008);
      cyc(0, 1, 1);
      check("pop_req_same", imem_req, 0);
      cyc(0, 0, 0);
      check("pop_req_next", imem_req, 1);
      check("pop_occ", occupancy, 3);

      // Slow memory: no ack for three cycles, address holds.
      cyc(0, 0, 1);
      check("wait_addr0", imem_addr, 16'h0008);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      check("wait_addr2", imem_addr, 16'h0008);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      check("wait_addr_after", imem_addr, 16'h000A);

      // Redirect coincident with an ack while three entries are queued.
      check("pre_redir_occ", occupancy, 3);
      cyc(0, 1, 0, 1, 16'h0100);
      check("redir_req", imem_req, 0);
      cyc(0, 0, 0);
      check("redir_occ", occupancy, 0);
      check("redir_valid", instr_valid, 0);
      check("redir_addr", imem_addr, 16'h0100);

      // PC wrap at the top of the address space.
      cyc(0, 0, 0, 1, 16'hFFFC);
      cyc(0, 1, 0);
      check("wrap_addr0", imem_addr, 16'hFFFC);
      cyc(0, 1, 0);
      check("wrap_addr1", imem_addr, 16'hFFFE);
      check("wrap_next1", fetch_pc_next, 16'h0000);
      cyc(0, 1, 0);
      check("wrap_addr2", imem_addr, 16'h0000);
      cyc(0, 1, 0);
      check("wrap_addr3", imem_addr, 16'h0002);
      cyc(0, 1, 1);
      check("wrap_head", instr_pc, 16'hFFFC);
      cyc(0, 0, 1);
      check("wrap_head2", instr_pc, 16'hFFFE);

      // Reset with a full queue and a pending request.
      repeat (3) cyc(0, 1, 0);
      check("pre_rst_occ", occupancy, 4);
      cyc(1, 1, 1);
      check("mid_rst_req", imem_req, 0);
      check("mid_rst_valid", instr_valid, 0);
      check("mid_rst_occ", occupancy, 0);
      cyc(0, 0, 0);
      check("restart_addr", imem_addr, 16'h0000);
      check("restart_req", imem_req, 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 9) < 6),
             ($urandom_range(0, 9) < 6),
             ($urandom_range(0, 29) == 0),
             AW'($urandom) & 16'hFFFE);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
